// File: rtl/ifft8_pkg.sv
// Shared types and constants for the 8-point iterative IFFT engine.
// Optional feature macro: IFFT8_SAT_FLAG_EN (adds a sticky saturation flag port).
package ifft8_pkg;

  localparam int unsigned DW   = 12;
  localparam int unsigned CW   = 2 * DW;
  localparam int          TW_C = 1448;  // cos(pi/4) in Q1.11
  localparam int          SMAX = 2 ** (DW - 1) - 1;
  localparam int          SMIN = -(2 ** (DW - 1));

  typedef enum logic [1:0] {
    StLoad,
    StComp,
    StUnload
  } state_e;

  // Butterfly schedule: three DIF stages of four butterflies each
  localparam logic [2:0] BF_A [12] = '{3'd0, 3'd1, 3'd2, 3'd3,
                                       3'd0, 3'd1, 3'd4, 3'd5,
                                       3'd0, 3'd2, 3'd4, 3'd6};
  localparam logic [2:0] BF_B [12] = '{3'd4, 3'd5, 3'd6, 3'd7,
                                       3'd2, 3'd3, 3'd6, 3'd7,
                                       3'd1, 3'd3, 3'd5, 3'd7};
  // Twiddle index: 0 = 1, 1 = (1+j)/sqrt2, 2 = j, 3 = (-1+j)/sqrt2
  localparam logic [1:0] BF_TW [12] = '{2'd0, 2'd1, 2'd2, 2'd3,
                                        2'd0, 2'd2, 2'd0, 2'd2,
                                        2'd0, 2'd0, 2'd0, 2'd0};

  function automatic logic [2:0] bitrev3(input logic [2:0] idx);
    return {idx[0], idx[1], idx[2]};
  endfunction

endpackage

// File: rtl/ifft8_engine_if.sv
// Streaming sample interface of the IFFT engine: input sample channel and output sample channel.
interface ifft8_engine_if;
  import ifft8_pkg::*;

  logic [CW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last
  );

endinterface

// File: rtl/ifft8_twiddle_mul.sv
// Combinational conjugate-twiddle multiplier for packed complex samples.
module ifft8_twiddle_mul
  import ifft8_pkg::*;
(
  input  logic [1:0]    tw_idx_i,
  input  logic [CW-1:0] data_i,
  output logic [CW-1:0] data_o,
  output logic          sat_o
);

  localparam int unsigned PW = 2 * DW + 2;

  logic signed [DW-1:0] re;
  logic signed [DW-1:0] im;
  logic signed [DW+1:0] r_plus_i;
  logic signed [DW+1:0] r_minus_i;
  logic        [DW:0]   rot_re;  // {sat, value}
  logic        [DW:0]   rot_im;

  // Multiply by cos(pi/4), round half up, clamp to the component range
  function automatic logic [DW:0] scale_c(input logic signed [DW+1:0] v);
    logic signed [PW-1:0] p;
    p = (PW'(v) * PW'(TW_C) + PW'(2 ** (DW - 2))) >>> (DW - 1);
    if (p > PW'(SMAX)) begin
      return {1'b1, DW'(SMAX)};
    end else if (p < PW'(SMIN)) begin
      return {1'b1, DW'(SMIN)};
    end
    return {1'b0, p[DW-1:0]};
  endfunction

  // Negation with the single overflow case clamped
  function automatic logic [DW:0] neg_sat(input logic signed [DW-1:0] v);
    if (v == DW'(SMIN)) begin
      return {1'b1, DW'(SMAX)};
    end
    return {1'b0, DW'(-v)};
  endfunction

  // Select rotation by twiddle index
  always_comb begin
    re        = data_i[CW-1:DW];
    im        = data_i[DW-1:0];
    r_plus_i  = (DW + 2)'(re) + (DW + 2)'(im);
    r_minus_i = (DW + 2)'(re) - (DW + 2)'(im);
    rot_re    = {1'b0, re};
    rot_im    = {1'b0, im};
    unique case (tw_idx_i)
      2'd0: begin
        rot_re = {1'b0, re};
        rot_im = {1'b0, im};
      end
      2'd1: begin
        rot_re = scale_c(r_minus_i);
        rot_im = scale_c(r_plus_i);
      end
      2'd2: begin
        rot_re = neg_sat(im);
        rot_im = {1'b0, re};
      end
      2'd3: begin
        rot_re = scale_c(-r_plus_i);
        rot_im = scale_c(r_minus_i);
      end
      default: ;
    endcase
    data_o = {rot_re[DW-1:0], rot_im[DW-1:0]};
    sat_o  = rot_re[DW] | rot_im[DW];
  end

endmodule

// File: rtl/ifft8_engine.sv
// Iterative 8-point radix-2 DIF inverse FFT: load 8 samples, 12 in-place butterflies,
// bit-reversed read-out in natural order. Optional macro IFFT8_SAT_FLAG_EN adds port sat.
module ifft8_engine
  import ifft8_pkg::*;
(
  input logic            clk,
  input logic            rst,
  ifft8_engine_if.slave  bus
`ifdef IFFT8_SAT_FLAG_EN
  ,
  output logic           sat
`endif
);

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [CW-1:0] mem_q [8];

  logic [2:0]    addr_a, addr_b;
  logic [1:0]    tw_idx;
  logic [CW-1:0] op_a, op_b, bf_sum, bf_diff, bf_tw;
  logic [DW:0]   s_re, s_im, d_re, d_im;
  logic          tw_sat;

  // Scheduled butterfly: halved sum and difference with 13-bit intermediates
  always_comb begin
    addr_a  = BF_A[cnt_q];
    addr_b  = BF_B[cnt_q];
    tw_idx  = BF_TW[cnt_q];
    op_a    = mem_q[addr_a];
    op_b    = mem_q[addr_b];
    s_re    = {op_a[CW-1], op_a[CW-1:DW]} + {op_b[CW-1], op_b[CW-1:DW]};
    s_im    = {op_a[DW-1], op_a[DW-1:0]} + {op_b[DW-1], op_b[DW-1:0]};
    d_re    = {op_a[CW-1], op_a[CW-1:DW]} - {op_b[CW-1], op_b[CW-1:DW]};
    d_im    = {op_a[DW-1], op_a[DW-1:0]} - {op_b[DW-1], op_b[DW-1:0]};
    bf_sum  = {s_re[DW:1], s_im[DW:1]};
    bf_diff = {d_re[DW:1], d_im[DW:1]};
  end

  ifft8_twiddle_mul u_tw (
    .tw_idx_i (tw_idx),
    .data_i   (bf_diff),
    .data_o   (bf_tw),
    .sat_o    (tw_sat)
  );

  // FSM state and shared counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StLoad;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: LOAD -> COMP -> UNLOAD -> LOAD
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StLoad: begin
        if (bus.in_valid) begin
          if (cnt_q == 4'd7) begin
            state_d = StComp;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      StComp: begin
        if (cnt_q == 4'd11) begin
          state_d = StUnload;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StUnload: begin
        if (bus.out_ready) begin
          if (cnt_q == 4'd7) begin
            state_d = StLoad;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = StLoad;
        cnt_d   = '0;
      end
    endcase
  end

  // Sample capture in LOAD, in-place write-back in COMP; contents need no reset
  always_ff @(posedge clk) begin
    if (state_q == StLoad && bus.in_valid) begin
      mem_q[cnt_q[2:0]] <= bus.in_data;
    end else if (state_q == StComp) begin
      mem_q[addr_a] <= bf_sum;
      mem_q[addr_b] <= bf_tw;
    end
  end

  // Handshake outputs; results sit bit-reversed in the array
  always_comb begin
    bus.in_ready  = (state_q == StLoad);
    bus.out_valid = (state_q == StUnload);
    bus.out_last  = (state_q == StUnload) && (cnt_q == 4'd7);
    bus.out_data  = '0;
    if (state_q == StUnload) begin
      bus.out_data = mem_q[bitrev3(cnt_q[2:0])];
    end
  end

`ifdef IFFT8_SAT_FLAG_EN
  logic sat_q;

  // Sticky flag: cleared when a new frame starts loading, set by any clamp in COMP
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_q <= 1'b0;
    end else if (state_d == StLoad && state_q != StLoad) begin
      sat_q <= 1'b0;
    end else if (state_q == StComp && tw_sat) begin
      sat_q <= 1'b1;
    end
  end

  assign sat = sat_q;
`else
  logic unused_tw_sat;
  assign unused_tw_sat = tw_sat;
`endif

endmodule
